fpu_ret_merge: RTL and testbench
================================

# fpu_ret_merge

Parametrised result-merge and retire buffer for the split-lane FP unit. It collects per-lane return codes, flag words and return-enables from `LANES` datapath slices on each of `CHANNELS` issue ports. For each op it ORs the lane return codes and picks the flag word by op type. It also checks that the lanes that answered match the lanes the op expected. Merged entries queue in a per-channel FIFO with a valid/ready retire handshake, so retire-side stalls no longer lose results.

## Interface
Parameters:
- `CHANNELS`, 3: number of independent issue/retire channels.
- `LANES`, 2: datapath slices per channel. Lane 0 is the low half; lane `LANES-1` is the high half.
- `RET_W`, 14: return code width.
- `FUS_W`, 6: flag word width.
- `OP_W`, 13: op width.
- `SEL_OP`, 8'h00: value of `op[7:0]` that selects the flag word from lane `op_lsel`. Set to the `fop_cmpDH` encoding at instantiation.
- `LAT`, 4: issue-to-lane-result latency in cycles, ≥1.
- `DEPTH`, 4: FIFO entries per channel, power of two, ≥2.
- `LSW`: $clog2(`LANES`), derived.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `op_en`, in, `CHANNELS`: op issued on channel c.
- `op`, in, `CHANNELS*OP_W`: issued op.
- `op_lmask`, in, `CHANNELS*LANES`: lanes expected to return for this op.
- `op_lsel`, in, `CHANNELS*LSW`: flag-source lane when `op[7:0]==SEL_OP`.
- `lane_ret`, in, `CHANNELS*LANES*RET_W`: lane return codes.
- `lane_ret_en`, in, `CHANNELS*LANES`: lane return valid.
- `lane_fus`, in, `CHANNELS*LANES*FUS_W`: lane flag words.
- `ret_valid`, out, `CHANNELS`: FIFO head valid.
- `ret_ready`, in, `CHANNELS`: retire side accepts the head.
- `ret_data`, out, `CHANNELS*RET_W`: head merged return code.
- `ret_fus`, out, `CHANNELS*FUS_W`: head selected flag word.
- `ret_err`, out, `CHANNELS`: head lane-mask mismatch.
- `ovf`, out, `CHANNELS`: sticky FIFO overflow.
- `stray`, out, `CHANNELS`: sticky flag for a lane return with no matching op.

## Operation
- Each channel is fully independent; no sharing between channels.
- Op tracking:
  - Each channel has a `LAT`-stage shift register per cycle holding {valid, `op[7:0]==SEL_OP`, `op_lmask`, `op_lsel`}.
  - Stage 0 is loaded from `op_en` and the op fields.
  - The last stage is the "due" slot.
- Merge, evaluated when the due slot is valid:
  - `m_ret` = OR of `lane_ret[l]` over lanes with `lane_ret_en[l]=1`.
  - `m_fus` = `lane_fus[op_lsel]` if the sel bit is set, else `lane_fus[0]`. The flag word is not gated by `lane_ret_en`.
  - `m_err` = (`lane_ret_en` != `op_lmask`).
  - {`m_ret`, `m_fus`, `m_err`} is pushed into the channel FIFO.
- Due slot invalid with any `lane_ret_en` high: nothing is pushed and `stray` is set.
- FIFO:
  - Read pointer, write pointer and count are each `$clog2(DEPTH)+1` bits; pointers wrap modulo `DEPTH`.
  - Pop occurs when `ret_valid & ret_ready`.
  - Push while full with a simultaneous pop is accepted; count is unchanged.
  - Push while full without a pop drops the entry and sets `ovf`; FIFO contents are unchanged.
  - Pop while empty is ignored; `ret_ready` has no effect when `ret_valid=0`.
- `ret_data`, `ret_fus` and `ret_err` are zero while `ret_valid=0`.
- `ovf` and `stray` stay set until `rst`.

## Timing
- Reset:
  - At the first rising edge with `rst=1`, all pipeline stages become invalid and every FIFO becomes empty.
  - Outputs after that edge: `ret_valid`=0, `ret_data`=0, `ret_fus`=0, `ret_err`=0, `ovf`=0, `stray`=0.
  - `rst` asserted mid-operation discards in-flight ops and queued entries.
  - Lane returns presented while `rst=1` are ignored and set no flags.
- Lane results for an op with `op_en` in cycle t must be presented in cycle t+`LAT`; they are sampled at the end of that cycle.
- Latency: `ret_valid` rises in cycle t+`LAT`+1 if the FIFO was empty. There is no combinational bypass.
- Back-to-back issue on every cycle is supported; throughput is 1 entry/cycle/channel while `ret_ready=1`.
- Handshake: the head must stay stable while `ret_valid & !ret_ready`. The next entry appears in the cycle after a pop.

## Test plan
- Basic merge, `LAT`=4, channel 0:
  - Stimulus: `op_en` at cycle 10 with `op[7:0]`≠`SEL_OP` and `op_lmask`=2'b11. At cycle 14: lane0 `ret`=14'h0010 en=1, lane1 `ret`=14'h0001 en=1, `fus`={6'h05, 6'h2A}.
  - Required: cycle 15 `ret_valid`=1, `ret_data`=14'h0011, `ret_fus`=6'h2A (lane 0), `ret_err`=0.
- Compare select: same as the basic merge but `op[7:0]`=`SEL_OP` and `op_lsel`=1 → `ret_fus`=6'h05.
- Mask mismatch: `op_lmask`=2'b11 with only lane0 en=1, `ret`=14'h0004 → `ret_data`=14'h0004, `ret_err`=1.
- Backpressure/overflow, `DEPTH`=4:
  - Stimulus: hold `ret_ready`=0 and issue 5 ops on consecutive cycles.
  - Required: 4 entries queue, `ovf`=1 from the 5th push edge, and the head stays unchanged. Raise `ret_ready` → exactly the first 4 entries drain in order, one per cycle, then `ret_valid`=0.
- Full with simultaneous push and pop: FIFO full, `ret_ready`=1 and a due push in the same cycle → `ovf` stays 0, count stays 4, and entry order is preserved.
- Stray and reset:
  - Stimulus: `lane_ret_en`=1 with no op due.
  - Required: `stray`=1 and no entry is queued.
  - Then assert `rst` for 1 cycle with 2 ops in flight and 2 entries queued → all outputs 0 afterwards, and no entry appears `LAT` cycles later.

Source files
------------

// File: rtl/fpu_ret_merge.sv
// Result-merge and retire buffer for the split-lane FP unit: per-channel op tracking,
// lane-result merge and a valid/ready retire FIFO.
module fpu_ret_merge #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned LANES    = 2,
  parameter int unsigned RET_W    = 14,
  parameter int unsigned FUS_W    = 6,
  parameter int unsigned OP_W     = 13,
  parameter logic [7:0]  SEL_OP   = 8'h00,
  parameter int unsigned LAT      = 4,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned LSW      = $clog2(LANES)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CHANNELS-1:0]               op_en,
  input  logic [CHANNELS*OP_W-1:0]          op,
  input  logic [CHANNELS*LANES-1:0]         op_lmask,
  input  logic [CHANNELS*LSW-1:0]           op_lsel,
  input  logic [CHANNELS*LANES*RET_W-1:0]   lane_ret,
  input  logic [CHANNELS*LANES-1:0]         lane_ret_en,
  input  logic [CHANNELS*LANES*FUS_W-1:0]   lane_fus,
  output logic [CHANNELS-1:0]               ret_valid,
  input  logic [CHANNELS-1:0]               ret_ready,
  output logic [CHANNELS*RET_W-1:0]         ret_data,
  output logic [CHANNELS*FUS_W-1:0]         ret_fus,
  output logic [CHANNELS-1:0]               ret_err,
  output logic [CHANNELS-1:0]               ovf,
  output logic [CHANNELS-1:0]               stray
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = RET_W + FUS_W + 1;

  // Only op[7:0] of each channel matters to the merge.
  logic unused_op;
  assign unused_op = ^op;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic             vld_q  [LAT];
    logic             sel_q  [LAT];
    logic [LANES-1:0] msk_q  [LAT];
    logic [LSW-1:0]   lsel_q [LAT];
    logic [EW-1:0]    mem_q  [DEPTH];

    logic [CW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    wptr_q, wptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             stray_q, stray_d;

    logic [LANES-1:0] ch_en;
    logic [RET_W-1:0] m_ret;
    logic [FUS_W-1:0] m_fus;
    logic             m_err;
    logic             due, empty, full, pop, push_ok;
    logic [EW-1:0]    head;

    assign ch_en = lane_ret_en[c*LANES +: LANES];
    assign due   = vld_q[LAT-1];

    always_comb begin
      m_ret = '0;
      m_fus = lane_fus[c*LANES*FUS_W +: FUS_W];
      for (int l = 0; l < LANES; l++) begin
        if (ch_en[l]) begin
          m_ret = m_ret | lane_ret[(c*LANES+l)*RET_W +: RET_W];
        end
        // Flag word comes from the selected lane regardless of its return-enable.
        if (sel_q[LAT-1] && (lsel_q[LAT-1] == LSW'(l))) begin
          m_fus = lane_fus[(c*LANES+l)*FUS_W +: FUS_W];
        end
      end
    end

    assign m_err   = (ch_en != msk_q[LAT-1]);
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign pop     = !empty && ret_ready[c];
    assign push_ok = due && (!full || pop);

    always_comb begin
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      stray_d = stray_q;
      if (pop) begin
        rptr_d = (rptr_q == CW'(DEPTH - 1)) ? '0 : rptr_q + CW'(1);
      end
      if (push_ok) begin
        wptr_d = (wptr_q == CW'(DEPTH - 1)) ? '0 : wptr_q + CW'(1);
      end
      case ({push_ok, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
      if (due && full && !pop) begin
        ovf_d = 1'b1;
      end
      if (!due && (ch_en != '0)) begin
        stray_d = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < LAT; i++) begin
          vld_q[i] <= 1'b0;
        end
        rptr_q  <= '0;
        wptr_q  <= '0;
        cnt_q   <= '0;
        ovf_q   <= 1'b0;
        stray_q <= 1'b0;
      end else begin
        vld_q[0] <= op_en[c];
        for (int i = 1; i < LAT; i++) begin
          vld_q[i] <= vld_q[i-1];
        end
        rptr_q  <= rptr_d;
        wptr_q  <= wptr_d;
        cnt_q   <= cnt_d;
        ovf_q   <= ovf_d;
        stray_q <= stray_d;
      end
    end

    // Payload registers need no reset: their valid bits and the FIFO count gate them.
    always_ff @(posedge clk) begin
      sel_q[0]  <= (op[c*OP_W +: 8] == SEL_OP);
      msk_q[0]  <= op_lmask[c*LANES +: LANES];
      lsel_q[0] <= op_lsel[c*LSW +: LSW];
      for (int i = 1; i < LAT; i++) begin
        sel_q[i]  <= sel_q[i-1];
        msk_q[i]  <= msk_q[i-1];
        lsel_q[i] <= lsel_q[i-1];
      end
      if (push_ok && !rst) begin
        mem_q[wptr_q[AW-1:0]] <= {m_err, m_fus, m_ret};
      end
    end

    assign head                          = mem_q[rptr_q[AW-1:0]];
    assign ret_valid[c]                  = !empty;
    assign ret_data[c*RET_W +: RET_W]    = empty ? '0 : head[RET_W-1:0];
    assign ret_fus[c*FUS_W +: FUS_W]     = empty ? '0 : head[RET_W +: FUS_W];
    assign ret_err[c]                    = empty ? 1'b0 : head[EW-1];
    assign ovf[c]                        = ovf_q;
    assign stray[c]                      = stray_q;
  end

endmodule

// File: tb/tb_fpu_ret_merge.sv
// Randomized bench for fpu_ret_merge against a queue-based model of op issue,
// lane merge and per-channel retire FIFO.
module tb_fpu_ret_merge;
  localparam int CH = 3;
  localparam int LN = 2;
  localparam int RW = 14;
  localparam int FW = 6;
  localparam int OW = 13;
  localparam int LAT = 4;
  localparam int DEPTH = 4;
  localparam int LSW = 1;
  localparam logic [7:0] SEL = 8'h5C;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [CH-1:0]        op_en;
  logic [CH*OW-1:0]     op;
  logic [CH*LN-1:0]     op_lmask;
  logic [CH*LSW-1:0]    op_lsel;
  logic [CH*LN*RW-1:0]  lane_ret;
  logic [CH*LN-1:0]     lane_ret_en;
  logic [CH*LN*FW-1:0]  lane_fus;
  logic [CH-1:0]        ret_valid;
  logic [CH-1:0]        ret_ready;
  logic [CH*RW-1:0]     ret_data;
  logic [CH*FW-1:0]     ret_fus;
  logic [CH-1:0]        ret_err;
  logic [CH-1:0]        ovf;
  logic [CH-1:0]        stray;

  fpu_ret_merge #(
    .CHANNELS(CH), .LANES(LN), .RET_W(RW), .FUS_W(FW), .OP_W(OW),
    .SEL_OP(SEL), .LAT(LAT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .op_en(op_en), .op(op), .op_lmask(op_lmask),
    .op_lsel(op_lsel), .lane_ret(lane_ret), .lane_ret_en(lane_ret_en),
    .lane_fus(lane_fus), .ret_valid(ret_valid), .ret_ready(ret_ready),
    .ret_data(ret_data), .ret_fus(ret_fus), .ret_err(ret_err), .ovf(ovf),
    .stray(stray)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       due;
    bit       sel;
    bit [1:0] msk;
    bit       lsel;
  } op_t;

  typedef struct {
    bit [RW-1:0] r;
    bit [FW-1:0] f;
    bit          e;
  } ent_t;

  op_t  pend [CH][$];
  ent_t fifo [CH][$];
  bit   m_ovf [CH];
  bit   m_stray [CH];
  int   cyc;
  int   checks;
  int   errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic compare_outputs();
    for (int c = 0; c < CH; c++) begin
      ent_t h;
      bit   ev;
      ev = fifo[c].size() > 0;
      if (ev) h = fifo[c][0];
      else begin
        h.r = '0;
        h.f = '0;
        h.e = 1'b0;
      end
      check($sformatf("valid%0d", c), 32'(ret_valid[c]), 32'(ev));
      check($sformatf("data%0d", c), 32'(ret_data[c*RW +: RW]), 32'(h.r));
      check($sformatf("fus%0d", c), 32'(ret_fus[c*FW +: FW]), 32'(h.f));
      check($sformatf("err%0d", c), 32'(ret_err[c]), 32'(h.e));
      check($sformatf("ovf%0d", c), 32'(ovf[c]), 32'(m_ovf[c]));
      check($sformatf("stray%0d", c), 32'(stray[c]), 32'(m_stray[c]));
    end
  endtask

  // One clock cycle: check registered outputs, drive random inputs, advance the model.
  task automatic cycle(input bit do_rst, input int p_issue, input int p_ready,
                       input int p_bad, input int p_stray);
    compare_outputs();
    rst = do_rst;
    for (int c = 0; c < CH; c++) begin
      bit            due_now;
      bit            sel;
      logic [OW-1:0] o;
      bit [1:0]      en;
      due_now = pend[c].size() > 0 && pend[c][0].due == cyc;

      o = OW'($urandom);
      sel = ($urandom_range(0, 1) == 1);
      if (sel) o[7:0] = SEL;
      else if (o[7:0] == SEL) o[7:0] = SEL ^ 8'h01;
      op[c*OW +: OW]      = o;
      op_en[c]            = !do_rst && ($urandom_range(0, 99) < p_issue);
      op_lmask[c*LN +: LN] = 2'($urandom_range(1, 3));
      op_lsel[c]          = 1'($urandom);

      for (int l = 0; l < LN; l++) begin
        lane_ret[(c*LN+l)*RW +: RW] = RW'($urandom);
        lane_fus[(c*LN+l)*FW +: FW] = FW'($urandom);
      end
      if (due_now) begin
        en = ($urandom_range(0, 99) < p_bad) ? 2'($urandom) : pend[c][0].msk;
      end else begin
        en = ($urandom_range(0, 99) < p_stray) ? 2'($urandom_range(1, 3)) : 2'b00;
      end
      lane_ret_en[c*LN +: LN] = en;
      ret_ready[c] = ($urandom_range(0, 99) < p_ready);

      if (!do_rst) begin
        bit pop;
        bit full;
        pop  = fifo[c].size() > 0 && ret_ready[c];
        full = fifo[c].size() == DEPTH;
        if (pop) void'(fifo[c].pop_front());
        if (due_now) begin
          op_t  p;
          ent_t e;
          p = pend[c].pop_front();
          e.r = '0;
          for (int l = 0; l < LN; l++) begin
            if (en[l]) e.r = e.r | lane_ret[(c*LN+l)*RW +: RW];
          end
          e.f = p.sel ? lane_fus[(c*LN + int'(p.lsel))*FW +: FW] : lane_fus[c*LN*FW +: FW];
          e.e = (en != p.msk);
          if (!full || pop) fifo[c].push_back(e);
          else m_ovf[c] = 1'b1;
        end else if (en != 2'b00) begin
          m_stray[c] = 1'b1;
        end
        if (op_en[c]) begin
          op_t n;
          n.due  = cyc + LAT;
          n.sel  = sel;
          n.msk  = op_lmask[c*LN +: LN];
          n.lsel = op_lsel[c];
          pend[c].push_back(n);
        end
      end
    end
    if (do_rst) begin
      for (int c = 0; c < CH; c++) begin
        pend[c].delete();
        fifo[c].delete();
        m_ovf[c]   = 1'b0;
        m_stray[c] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n, input bit do_rst, input int p_issue, input int p_ready,
                     input int p_bad, input int p_stray);
    for (int i = 0; i < n; i++) cycle(do_rst, p_issue, p_ready, p_bad, p_stray);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    rst = 1'b1;
    op_en = '0;
    op = '0;
    op_lmask = '0;
    op_lsel = '0;
    lane_ret = '0;
    lane_ret_en = '0;
    lane_fus = '0;
    ret_ready = '0;
    @(posedge clk);
    #1;
    cyc++;

    run(2, 1'b1, 0, 0, 0, 0);
    // Mixed traffic with mask mismatches.
    run(200, 1'b0, 60, 70, 20, 0);
    run(1, 1'b1, 0, 0, 0, 0);
    // Fill to exactly DEPTH, then push and pop together while full.
    run(LAT + 4, 1'b0, 100, 0, 0, 0);
    run(20, 1'b0, 100, 100, 10, 0);
    run(LAT + 2, 1'b0, 0, 100, 0, 0);
    // Overflow under stall, then drain.
    run(12, 1'b0, 100, 0, 0, 0);
    run(15, 1'b0, 0, 100, 0, 0);
    // Stray returns with nothing due.
    run(10, 1'b0, 0, 50, 0, 50);
    run(1, 1'b1, 0, 0, 0, 0);
    // Reset with ops in flight and entries queued.
    run(LAT + 2, 1'b0, 100, 0, 0, 0);
    run(1, 1'b1, 0, 0, 0, 0);
    run(2 * LAT, 1'b0, 0, 100, 0, 0);
    // Long random soak with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) == 0, 70, 60, 25, 5);
    end
    run(LAT + 1, 1'b0, 0, 100, 0, 0);
    compare_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
